// File: rtl/cntr_pkg.sv
// Shared constants and FSM state type for the bank command arbiter.
package cntr_pkg;

    // Request / bus-mode encoding shared with the bank schedulers.
    localparam logic READ  = 1'b0;
    localparam logic WRITE = 1'b1;

    // Bus mode FSM: read phase, read-to-write bubble, write phase, write-to-read bubble.
    typedef enum logic [1:0] {
        ST_RD    = 2'd0,
        ST_RD2WR = 2'd1,
        ST_WR    = 2'd2,
        ST_WR2RD = 2'd3
    } mode_state_e;

    // Bus direction implied by a state: the bubble keeps the direction it is leaving.
    function automatic logic state_mode(input mode_state_e s);
        return (s == ST_WR || s == ST_WR2RD) ? WRITE : READ;
    endfunction

endpackage

// File: rtl/cntr_rr_arb.sv
// Round-robin picker: one-hot grant to the first requester after ptr, wrapping.
module cntr_rr_arb #(
    parameter int unsigned N  = 4,
    parameter int unsigned PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant
);

    logic          found;
    logic [PW-1:0] idx;

    // Scan N positions starting one past the last winner; first hit wins.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 1; i <= N; i++) begin
            idx = PW'((32'(ptr) + i) % N);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cntr_bank_arb.sv
// Bank command arbiter: picks one bank request per cycle in the current bus
// direction, switches read/write phases on write-count watermarks with a
// fixed turnaround bubble, and registers the winning request for the
// downstream command path.
// Optional build macro CNTR_BANK_ARB_STARVE_EN adds a starvation counter that
// forces a direction change after STARVE_MAX cycles of opposite-type backlog.
module cntr_bank_arb
    import cntr_pkg::*;
#(
    parameter int unsigned BANKS      = 4,
    parameter int unsigned RA         = 16,
    parameter int unsigned CA         = 10,
    parameter int unsigned DQ         = 16,
    parameter int unsigned IDX        = 7,
    parameter int unsigned WR_BITS    = 3,
    parameter int unsigned HI_WM      = 6,
    parameter int unsigned LO_WM      = 1,
    parameter int unsigned TURN       = 2,
    parameter int unsigned STARVE_MAX = 64
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [BANKS-1:0]             valid_i,
    input  logic [BANKS-1:0]             t_i,
    input  logic [BANKS*DQ-1:0]          dq_i,
    input  logic [BANKS*IDX-1:0]         idx_i,
    input  logic [BANKS*RA-1:0]          ra_i,
    input  logic [BANKS*CA-1:0]          ca_i,
    input  logic [BANKS*WR_BITS-1:0]     num_i,
    input  logic [BANKS-1:0]             rd_empty_i,
    output logic [BANKS-1:0]             ready_o,
    output logic                         mode_o,
    input  logic                         ready_i,
    output logic                         valid_o,
    output logic                         t_o,
    output logic [DQ-1:0]                dq_o,
    output logic [IDX-1:0]               idx_o,
    output logic [RA-1:0]                ra_o,
    output logic [CA-1:0]                ca_o,
    output logic [$clog2(BANKS)-1:0]     bank_o
);

    localparam int unsigned BW  = $clog2(BANKS);
    localparam int unsigned TW  = WR_BITS + $clog2(BANKS);
    localparam int unsigned TCW = (TURN > 1) ? $clog2(TURN) : 1;

    // Zero-cycle bubbles or a zero starvation limit are not meaningful.
    if (TURN < 1 || STARVE_MAX < 1) begin : g_param_guard
    end

    mode_state_e      state_q, state_d;
    logic [TCW-1:0]   turn_q, turn_d;
    logic [BW-1:0]    ptr_q;
    logic [TW-1:0]    wr_total;
    logic             all_rd_empty;
    logic             in_xfer;
    logic [BANKS-1:0] eligible;
    logic [BANKS-1:0] grant;
    logic             can_drain;
    logic             load_en;
    logic             go_write;
    logic             go_read;
    logic             starve_hit;
    logic [BW-1:0]    win_idx;
    logic             sel_t;
    logic [DQ-1:0]    sel_dq;
    logic [IDX-1:0]   sel_idx;
    logic [RA-1:0]    sel_ra;
    logic [CA-1:0]    sel_ca;

    // Total pending writes across banks, sized so it cannot overflow.
    always_comb begin
        wr_total = '0;
        for (int unsigned b = 0; b < BANKS; b++) begin
            wr_total = wr_total + TW'(num_i[b*WR_BITS +: WR_BITS]);
        end
    end

    assign all_rd_empty = &rd_empty_i;
    assign mode_o       = state_mode(state_q);
    assign in_xfer      = (state_q == ST_RD) || (state_q == ST_WR);
    assign eligible     = in_xfer ? (valid_i & ~(t_i ^ {BANKS{mode_o}})) : '0;
    assign can_drain    = !valid_o || ready_i;
    assign load_en      = rst_n && can_drain && (|eligible);
    assign ready_o      = load_en ? grant : '0;

    assign go_write = (wr_total >= TW'(HI_WM)) || (all_rd_empty && (wr_total != '0));
    assign go_read  = ((wr_total <= TW'(LO_WM)) && !all_rd_empty) ||
                      ((wr_total == '0) && !all_rd_empty);

    cntr_rr_arb #(
        .N  (BANKS),
        .PW (BW)
    ) u_rr (
        .req   (eligible),
        .ptr   (ptr_q),
        .grant (grant)
    );

    // Winner index and payload mux from the one-hot grant.
    always_comb begin
        win_idx = '0;
        sel_t   = 1'b0;
        sel_dq  = '0;
        sel_idx = '0;
        sel_ra  = '0;
        sel_ca  = '0;
        for (int unsigned b = 0; b < BANKS; b++) begin
            if (grant[b]) begin
                win_idx = BW'(b);
                sel_t   = t_i[b];
                sel_dq  = dq_i[b*DQ +: DQ];
                sel_idx = idx_i[b*IDX +: IDX];
                sel_ra  = ra_i[b*RA +: RA];
                sel_ca  = ca_i[b*CA +: CA];
            end
        end
    end

`ifdef CNTR_BANK_ARB_STARVE_EN
    localparam int unsigned SCW = $clog2(STARVE_MAX + 1);

    logic [SCW-1:0] starve_q;
    logic           starve_pend;

    assign starve_pend = (state_q == ST_RD) ? (|(valid_i & t_i))  :
                         (state_q == ST_WR) ? (|(valid_i & ~t_i)) : 1'b0;
    assign starve_hit  = (starve_q == SCW'(STARVE_MAX));

    // Count cycles the opposite direction has been waiting; saturates at the limit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_q <= '0;
        end else if (!starve_pend) begin
            starve_q <= '0;
        end else if (!starve_hit) begin
            starve_q <= starve_q + 1'b1;
        end
    end
`else
    assign starve_hit = 1'b0;
`endif

    // Next-state logic: phases only exit when the output register can drain;
    // bubbles count down TURN cycles unconditionally.
    always_comb begin
        state_d = state_q;
        turn_d  = turn_q;
        case (state_q)
            ST_RD: begin
                if (can_drain && (go_write || starve_hit)) begin
                    state_d = ST_RD2WR;
                    turn_d  = TCW'(TURN - 1);
                end
            end
            ST_RD2WR: begin
                if (turn_q == '0) state_d = ST_WR;
                else              turn_d  = turn_q - 1'b1;
            end
            ST_WR: begin
                if (can_drain && (go_read || starve_hit)) begin
                    state_d = ST_WR2RD;
                    turn_d  = TCW'(TURN - 1);
                end
            end
            ST_WR2RD: begin
                if (turn_q == '0) state_d = ST_RD;
                else              turn_d  = turn_q - 1'b1;
            end
            default: begin
                state_d = ST_RD;
                turn_d  = '0;
            end
        endcase
    end

    // State, pointer and output request register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_RD;
            turn_q  <= '0;
            ptr_q   <= '0;
            valid_o <= 1'b0;
            t_o     <= 1'b0;
            dq_o    <= '0;
            idx_o   <= '0;
            ra_o    <= '0;
            ca_o    <= '0;
            bank_o  <= '0;
        end else begin
            state_q <= state_d;
            turn_q  <= turn_d;
            if (load_en) begin
                ptr_q   <= win_idx;
                valid_o <= 1'b1;
                t_o     <= sel_t;
                dq_o    <= sel_dq;
                idx_o   <= sel_idx;
                ra_o    <= sel_ra;
                ca_o    <= sel_ca;
                bank_o  <= win_idx;
            end else if (ready_i) begin
                valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cntr_bank_arb.sv
// Self-checking bench for cntr_bank_arb: per-scenario tasks plus a payload
// scoreboard filled on each grant and drained on each output transfer.
module tb_cntr_bank_arb;

    localparam int unsigned BANKS      = 4;
    localparam int unsigned RA         = 16;
    localparam int unsigned CA         = 10;
    localparam int unsigned DQ         = 16;
    localparam int unsigned IDX        = 7;
    localparam int unsigned WR_BITS    = 3;
    localparam int unsigned HI_WM      = 6;
    localparam int unsigned LO_WM      = 1;
    localparam int unsigned TURN       = 2;
    localparam int unsigned STARVE_MAX = 64;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [BANKS-1:0]         valid_i;
    logic [BANKS-1:0]         t_i;
    logic [BANKS*DQ-1:0]      dq_i;
    logic [BANKS*IDX-1:0]     idx_i;
    logic [BANKS*RA-1:0]      ra_i;
    logic [BANKS*CA-1:0]      ca_i;
    logic [BANKS*WR_BITS-1:0] num_i;
    logic [BANKS-1:0]         rd_empty_i;
    logic [BANKS-1:0]         ready_o;
    logic                     mode_o;
    logic                     ready_i;
    logic                     valid_o;
    logic                     t_o;
    logic [DQ-1:0]            dq_o;
    logic [IDX-1:0]           idx_o;
    logic [RA-1:0]            ra_o;
    logic [CA-1:0]            ca_o;
    logic [1:0]               bank_o;

    typedef struct packed {
        logic           t;
        logic [DQ-1:0]  dq;
        logic [IDX-1:0] idx;
        logic [RA-1:0]  ra;
        logic [CA-1:0]  ca;
        logic [1:0]     bank;
    } req_t;

    req_t        sb[$];
    int unsigned tag;
    int          nvec;
    int          nfail;

    cntr_bank_arb #(
        .BANKS(BANKS), .RA(RA), .CA(CA), .DQ(DQ), .IDX(IDX), .WR_BITS(WR_BITS),
        .HI_WM(HI_WM), .LO_WM(LO_WM), .TURN(TURN), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .t_i(t_i), .dq_i(dq_i),
        .idx_i(idx_i), .ra_i(ra_i), .ca_i(ca_i), .num_i(num_i),
        .rd_empty_i(rd_empty_i), .ready_o(ready_o), .mode_o(mode_o),
        .ready_i(ready_i), .valid_o(valid_o), .t_o(t_o), .dq_o(dq_o),
        .idx_o(idx_o), .ra_o(ra_o), .ca_o(ca_o), .bank_o(bank_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic req_t bank_req(input int unsigned b, input int unsigned tg, input logic t);
        req_t r;
        r.t    = t;
        r.dq   = DQ'(tg * 16 + b);
        r.idx  = IDX'(tg * 3 + b);
        r.ra   = RA'(32'h5000 + tg * 8 + b);
        r.ca   = CA'(tg * 5 + b);
        r.bank = 2'(b);
        return r;
    endfunction

    task automatic load_payload();
        req_t r;
        for (int unsigned b = 0; b < BANKS; b++) begin
            r = bank_req(b, tag, 1'b0);
            dq_i[b*DQ +: DQ]    = r.dq;
            idx_i[b*IDX +: IDX] = r.idx;
            ra_i[b*RA +: RA]    = r.ra;
            ca_i[b*CA +: CA]    = r.ca;
        end
    endtask

    // Sample at the falling edge: drain/fill the scoreboard and check one-hot ready_o.
    task automatic sample();
        req_t act, exp_r;
        @(negedge clk);
        if (rst_n) begin
            nvec++;
            if ($countones(ready_o) > 1) begin
                nfail++;
                $display("FAIL ready_onehot: ready_o=%b required at most one bit", ready_o);
            end
            if (valid_o && ready_i) begin
                nvec++;
                act = {t_o, dq_o, idx_o, ra_o, ca_o, bank_o};
                if (sb.size() == 0) begin
                    nfail++;
                    $display("FAIL sb_underflow: transfer %h with no grant outstanding", act);
                end else begin
                    exp_r = sb.pop_front();
                    if (act !== exp_r) begin
                        nfail++;
                        $display("FAIL payload: got %h required %h", act, exp_r);
                    end
                end
            end
            for (int unsigned b = 0; b < BANKS; b++)
                if (ready_o[b]) sb.push_back(bank_req(b, tag, t_i[b]));
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        tag++;
        load_payload();
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        valid_i    = '0;
        t_i        = '0;
        num_i      = '0;
        rd_empty_i = '0;
        ready_i    = 1'b1;
        advance();
        advance();
        sb.delete();
        rst_n = 1'b1;
    endtask

    task automatic drain_check(input string name);
        valid_i = '0;
        ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sample();
            advance();
        end
        nvec++;
        if (sb.size() != 0) begin
            nfail++;
            $display("FAIL %s_drain: %0d requests never transferred, required 0", name, sb.size());
        end
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        valid_i    = '1;
        t_i        = '0;
        num_i      = '0;
        rd_empty_i = '0;
        ready_i    = 1'b1;
        advance();
        sample();
        nvec++;
        if (ready_o !== 4'b0000) begin
            nfail++;
            $display("FAIL reset_ready: ready_o=%b required 0000", ready_o);
        end
        nvec++;
        if ({valid_o, mode_o, t_o, dq_o, idx_o, ra_o, ca_o, bank_o} !== '0) begin
            nfail++;
            $display("FAIL reset_outputs: valid=%b mode=%b dq=%h ra=%h bank=%0d required all 0",
                     valid_o, mode_o, dq_o, ra_o, bank_o);
        end
        advance();
        sb.delete();
    endtask

    task automatic test_rr_reads();
        do_reset();
        valid_i = 4'b0101;
        t_i     = '0;
        for (int k = 0; k < 8; k++) begin
            sample();
            nvec++;
            if (ready_o !== ((k % 2 == 0) ? 4'b0100 : 4'b0001)) begin
                nfail++;
                $display("FAIL rr_ready[%0d]: ready_o=%b required %b", k, ready_o,
                         (k % 2 == 0) ? 4'b0100 : 4'b0001);
            end
            nvec++;
            if (valid_o !== (k != 0) || mode_o !== 1'b0) begin
                nfail++;
                $display("FAIL rr_valid_mode[%0d]: valid_o=%b mode_o=%b required %b 0", k,
                         valid_o, mode_o, k != 0);
            end
            advance();
        end
        drain_check("rr");
    endtask

    task automatic test_turnaround();
        logic [3:0] er[8];
        logic       em[8];
        logic       ev[8];
        er = '{4'b0010, 4'b0000, 4'b0000, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b0010};
        em = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        ev = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        do_reset();
        valid_i = 4'b1010;
        t_i     = 4'b1000;
        num_i   = {3'd0, 3'd0, 3'd3, 3'd3};
        for (int k = 0; k < 8; k++) begin
            if (k == 4) num_i = {3'd0, 3'd0, 3'd0, 3'd1};
            sample();
            nvec++;
            if (ready_o !== er[k] || mode_o !== em[k] || valid_o !== ev[k]) begin
                nfail++;
                $display("FAIL turn[%0d]: ready_o=%b mode_o=%b valid_o=%b required %b %b %b",
                         k, ready_o, mode_o, valid_o, er[k], em[k], ev[k]);
            end
            advance();
        end
        drain_check("turn");
    endtask

    task automatic test_backpressure();
        int unsigned tag0;
        do_reset();
        valid_i = 4'b1111;
        t_i     = '0;
        tag0    = tag;
        sample();
        nvec++;
        if (ready_o !== 4'b0010) begin
            nfail++;
            $display("FAIL bp_first: ready_o=%b required 0010", ready_o);
        end
        advance();
        ready_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            sample();
            nvec++;
            if (ready_o !== 4'b0000 || valid_o !== 1'b1 ||
                dq_o !== DQ'(tag0 * 16 + 1) || ra_o !== RA'(32'h5000 + tag0 * 8 + 1)) begin
                nfail++;
                $display("FAIL bp_hold[%0d]: ready_o=%b valid_o=%b dq_o=%h ra_o=%h required 0000 1 %h %h",
                         k, ready_o, valid_o, dq_o, ra_o, DQ'(tag0 * 16 + 1),
                         RA'(32'h5000 + tag0 * 8 + 1));
            end
            advance();
        end
        ready_i = 1'b1;
        sample();
        nvec++;
        if (ready_o !== 4'b0100) begin
            nfail++;
            $display("FAIL bp_release: ready_o=%b required 0100", ready_o);
        end
        advance();
        drain_check("bp");
    endtask

    task automatic test_starve();
        int first_wr;
        int exp_first;
`ifdef CNTR_BANK_ARB_STARVE_EN
        exp_first = STARVE_MAX + 1 + TURN;
`else
        exp_first = -1;
`endif
        first_wr = -1;
        do_reset();
        valid_i = 4'b0101;
        t_i     = 4'b0100;
        num_i   = {3'd0, 3'd1, 3'd0, 3'd0};
        for (int k = 0; k < 100; k++) begin
            sample();
            if (mode_o && first_wr < 0) first_wr = k;
            advance();
        end
        nvec++;
        if (first_wr != exp_first) begin
            nfail++;
            $display("FAIL starve_switch: first write-mode cycle %0d required %0d", first_wr, exp_first);
        end
        drain_check("starve");
    endtask

    task automatic test_reset_mid_turn();
        do_reset();
        valid_i = 4'b0001;
        t_i     = '0;
        num_i   = {3'd0, 3'd0, 3'd3, 3'd3};
        ready_i = 1'b0;
        sample();
        nvec++;
        if (ready_o !== 4'b0001) begin
            nfail++;
            $display("FAIL rmid_grant: ready_o=%b required 0001", ready_o);
        end
        advance();
        sample();
        nvec++;
        if (valid_o !== 1'b1 || ready_o !== 4'b0000 || mode_o !== 1'b0) begin
            nfail++;
            $display("FAIL rmid_pending: valid_o=%b ready_o=%b mode_o=%b required 1 0000 0",
                     valid_o, ready_o, mode_o);
        end
        advance();
        rst_n = 1'b0;
        sample();
        advance();
        sb.delete();
        rst_n   = 1'b1;
        num_i   = '0;
        ready_i = 1'b1;
        sample();
        nvec++;
        if (valid_o !== 1'b0 || mode_o !== 1'b0 || ready_o !== 4'b0001) begin
            nfail++;
            $display("FAIL rmid_after: valid_o=%b mode_o=%b ready_o=%b required 0 0 0001",
                     valid_o, mode_o, ready_o);
        end
        advance();
        drain_check("rmid");
    endtask

    initial begin
        nvec       = 0;
        nfail      = 0;
        tag        = 0;
        rst_n      = 1'b0;
        valid_i    = '0;
        t_i        = '0;
        num_i      = '0;
        rd_empty_i = '0;
        ready_i    = 1'b1;
        load_payload();
        #1;
        test_reset();
        test_rr_reads();
        test_turnaround();
        test_backpressure();
        test_starve();
        test_reset_mid_turn();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
